// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
// Default geometry of the register file and the address-width derivation.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_NUM_RD   = 2;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_w(input int num_regs);
        int w;
        w = $clog2(num_regs);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enable-gated binary-to-one-hot decoder.
// Drives the write wordlines and the issue decode of the register file.
module onehot_decoder #(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0]      in,
    input  logic                 en,
    output logic [2**IN_W-1:0]   out
);

    // Exactly one output line high when enabled, all low otherwise.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_nr1w.sv
// Register file: one write port, NUM_RD combinational read ports and a
// per-register busy scoreboard.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data
// (and clear the matching read busy flag) onto the read ports.
module regfile_nr1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = addr_w(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic [NUM_REGS-1:0]        wr_wordline
);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] iss_line;
    logic                wr_ok;
    logic                iss_ok;

    // Register 0 is hardwired when ZERO_REG is set: writes and issues to it
    // never reach a wordline, so it can neither change nor become busy.
    assign wr_ok  = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
    assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    onehot_decoder #(.IN_W(ADDR_W)) u_wr_dec (
        .in  (wr_addr),
        .en  (wr_ok),
        .out (wr_wordline)
    );

    onehot_decoder #(.IN_W(ADDR_W)) u_iss_dec (
        .in  (issue_addr),
        .en  (iss_ok),
        .out (iss_line)
    );

    // Storage array: the selected wordline loads the writeback value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_wordline[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; a same-cycle issue wins
    // because the new producer supersedes the completing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~wr_wordline) | iss_line;
        end
    end

    assign busy_vec = busy_q;

    genvar k;
    for (k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        logic              zero_hit;
        logic [DATA_W-1:0] port_data;
        logic              port_busy;

        assign sel      = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (sel == '0);

        // Read mux for this port; busy registers still return stored data.
        always_comb begin
            port_data = mem[sel];
            port_busy = busy_q[sel];
`ifdef RF_BYPASS_EN
            if (wr_wordline[sel]) begin
                port_data = wr_data;
                port_busy = iss_line[sel];
            end
`endif
            if (zero_hit) begin
                port_data = '0;
                port_busy = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = port_data;
        assign rd_busy[k]                  = port_busy;
    end

endmodule

// File: tb/tb_regfile_nr1w.sv
// Directed and randomised bench for regfile_nr1w (16x16/2 ports and 32x16/3 ports).
module tb_regfile_nr1w;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic [15:0] busy_vec;
    logic [15:0] wr_wordline;

    logic        b_wr_en = 1'b0;
    logic [4:0]  b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic        b_issue_en = 1'b0;
    logic [4:0]  b_issue_addr = '0;
    logic [14:0] b_rd_addr = '0;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [31:0] b_busy_vec;
    logic [31:0] b_wr_wordline;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_nr1w dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .busy_vec(busy_vec), .wr_wordline(wr_wordline)
    );

    regfile_nr1w #(.NUM_REGS(32), .NUM_RD(3)) dut_big (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .issue_en(b_issue_en), .issue_addr(b_issue_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .busy_vec(b_busy_vec), .wr_wordline(b_wr_wordline)
    );

    task automatic idle_inputs();
        wr_en = 1'b0; issue_en = 1'b0;
        b_wr_en = 1'b0; b_issue_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) begin
            rd_addr = {4'(15 - r), 4'(r)};
            #1;
            tests++;
            if (rd_data[15:0] !== 16'h0000) begin
                fails++;
                $display("FAIL reset_rd0 r%0d: got %h want 0000", r, rd_data[15:0]);
            end
            tests++;
            if (rd_data[31:16] !== 16'h0000) begin
                fails++;
                $display("FAIL reset_rd1 r%0d: got %h want 0000", 15 - r, rd_data[31:16]);
            end
        end
        tests++;
        if (busy_vec !== 16'h0000 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_busy: busy_vec %h rd_busy %b want 0000/00", busy_vec, rd_busy);
        end
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5;
        rd_addr = {4'd3, 4'd1};
        #1;
        tests++;
        if (wr_wordline !== 16'h0008) begin
            fails++;
            $display("FAIL wr_wordline_r3: got %h want 0008", wr_wordline);
        end
        tests++;
        if (rd_data[31:16] !== (BYP ? 16'hA5A5 : 16'h0000)) begin
            fails++;
            $display("FAIL raw_same_cycle: got %h want %h", rd_data[31:16], BYP ? 16'hA5A5 : 16'h0000);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        tests++;
        if (rd_data[31:16] !== 16'hA5A5) begin
            fails++;
            $display("FAIL readback_r3: got %h want a5a5", rd_data[31:16]);
        end
        tests++;
        if (rd_data[15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL readback_r1: got %h want 0000", rd_data[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        issue_en = 1'b1; issue_addr = 4'd0;
        rd_addr = {4'd0, 4'd0};
        #1;
        tests++;
        if (wr_wordline !== 16'h0000) begin
            fails++;
            $display("FAIL zero_wordline: got %h want 0000", wr_wordline);
        end
        tests++;
        if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL zero_same_cycle: data %h busy %b want 0/00", rd_data, rd_busy);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (rd_data[15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL zero_read: got %h want 0000", rd_data[15:0]);
        end
        tests++;
        if (busy_vec !== 16'h0000) begin
            fails++;
            $display("FAIL zero_busy: got %h want 0000", busy_vec);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 4'd5;
        rd_addr = {4'd3, 4'd5};
        @(negedge clk);
        issue_en = 1'b0;
        #1;
        tests++;
        if (busy_vec !== 16'h0020 || rd_busy !== 2'b01) begin
            fails++;
            $display("FAIL sb_issue: busy_vec %h rd_busy %b want 0020/01", busy_vec, rd_busy);
        end
        tests++;
        if (rd_data[31:16] !== 16'hA5A5) begin
            fails++;
            $display("FAIL sb_unrelated_read: got %h want a5a5", rd_data[31:16]);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0055;
        issue_en = 1'b1; issue_addr = 4'd5;
        #1;
        tests++;
        if (rd_busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL sb_collide_rdbusy: got %b want 1", rd_busy[0]);
        end
        @(negedge clk);
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        tests++;
        if (busy_vec !== 16'h0020) begin
            fails++;
            $display("FAIL sb_collide: got %h want 0020", busy_vec);
        end
        tests++;
        if (rd_data[15:0] !== 16'h0055) begin
            fails++;
            $display("FAIL sb_busy_read: got %h want 0055", rd_data[15:0]);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0066;
        #1;
        tests++;
        if (rd_busy[0] !== (BYP ? 1'b0 : 1'b1)) begin
            fails++;
            $display("FAIL sb_clear_rdbusy: got %b want %b", rd_busy[0], BYP ? 1'b0 : 1'b1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        tests++;
        if (busy_vec !== 16'h0000) begin
            fails++;
            $display("FAIL sb_clear: got %h want 0000", busy_vec);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234;
        rd_addr = {4'd7, 4'd9};
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (busy_vec !== 16'h0080 || rd_data[15:0] !== 16'h1234) begin
            fails++;
            $display("FAIL arst_pre: busy_vec %h r9 %h want 0080/1234", busy_vec, rd_data[15:0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy_vec !== 16'h0000 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL arst_busy: busy_vec %h rd_busy %b want 0000/00", busy_vec, rd_busy);
        end
        tests++;
        if (rd_data[15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL arst_data: r9 %h want 0000", rd_data[15:0]);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] m_mem [32];
        logic        m_busy [32];
        logic [31:0] m_vec;
        logic [4:0]  a;
        logic [15:0] exp_d;
        logic        exp_b;
        logic        w_act, i_act;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            b_wr_en      = ($urandom_range(0, 3) != 0);
            b_wr_addr    = 5'($urandom_range(0, 31));
            b_wr_data    = 16'($urandom);
            b_issue_en   = ($urandom_range(0, 2) == 0);
            b_issue_addr = 5'($urandom_range(0, 31));
            b_rd_addr    = 15'($urandom);
            if ($urandom_range(0, 3) == 0) b_rd_addr[4:0] = b_wr_addr;
            if ($urandom_range(0, 3) == 0) b_rd_addr[9:5] = b_issue_addr;
            w_act = b_wr_en && (b_wr_addr != 5'd0);
            i_act = b_issue_en && (b_issue_addr != 5'd0);
            #1;
            for (int k = 0; k < 3; k++) begin
                a = b_rd_addr[k*5 +: 5];
                exp_d = m_mem[a];
                exp_b = m_busy[a];
                if (BYP && w_act && b_wr_addr == a) begin
                    exp_d = b_wr_data;
                    exp_b = i_act && (b_issue_addr == a);
                end
                if (a == 5'd0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end
                tests++;
                if (b_rd_data[k*16 +: 16] !== exp_d) begin
                    fails++;
                    $display("FAIL rand_rd_data c%0d p%0d r%0d: got %h want %h", c, k, a, b_rd_data[k*16 +: 16], exp_d);
                end
                tests++;
                if (b_rd_busy[k] !== exp_b) begin
                    fails++;
                    $display("FAIL rand_rd_busy c%0d p%0d r%0d: got %b want %b", c, k, a, b_rd_busy[k], exp_b);
                end
            end
            for (int i = 0; i < 32; i++) m_vec[i] = m_busy[i];
            tests++;
            if (b_busy_vec !== m_vec) begin
                fails++;
                $display("FAIL rand_busy_vec c%0d: got %h want %h", c, b_busy_vec, m_vec);
            end
            if (w_act) begin
                m_mem[b_wr_addr]  = b_wr_data;
                m_busy[b_wr_addr] = 1'b0;
            end
            if (i_act) m_busy[b_issue_addr] = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_scoreboard();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
